washing_machine_plant_model: RTL and testbench
==============================================

Name: washing_machine_plant_model

Overview:
- Cycle-based physical model of the washer: consumes the controller's actuator commands (water_valve, drain_pump, heater, drum_motor, door_lock) and produces the sensor signals the controller reads (water_level_sensor, temperature_adc_sensor, vibration_sensor, door_locked).
- Closes the loop around the main controller in system-level simulation and on the FPGA demo board.
- Fault-inject inputs drive the controller's water-flow, drainage and vibration error paths.

Parameters:
- TICK_DIV, 5: clk cycles per physics tick. Matches the controller's clk_freq.
- FILL_RATE, 4: level units added per tick while filling.
- DRAIN_RATE, 8: level units removed per tick while draining.
- LEVEL_MAX, 1023: saturation ceiling for water level.
- MIN_HEAT_LEVEL, 50: minimum water level for the heater to have any effect.
- HEAT_DIV, 3: ticks per +1 degC while heating.
- COOL_DIV, 10: ticks per -1 degC while cooling.
- AMBIENT_TEMP, 20: reset temperature and cooling floor.
- TEMP_MAX, 100: heating ceiling.
- LOCK_DELAY, 8: clk cycles for the lock mechanism to engage or release.
- DOOR_SAFE_LEVEL, 10: water level strictly below which unlock may complete.
- VIB_THRESH, 12: minimum drum_motor code that can excite vibration.
- VIB_PERSIST, 4: consecutive qualifying ticks before vibration_sensor asserts.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-low reset.
- water_valve  in  1: fill command.
- drain_pump  in  1: drain command.
- heater  in  1: heater command.
- drum_motor  in  4: drum speed code, 0 = stopped.
- door_lock  in  1: lock request.
- inject_no_water  in  1: supply failure; the valve has no effect.
- inject_drain_block  in  1: blocked drain; the pump has no effect.
- inject_imbalance  in  1: unbalanced load.
- water_level_sensor  out  10: modelled water level.
- temperature_adc_sensor  out  7: modelled water temperature in degC.
- vibration_sensor  out  1: excessive vibration.
- door_locked  out  1: mechanical lock state.

Behaviour:
- Reset (reset=0, asynchronous):
  - water_level_sensor=0, temperature_adc_sensor=AMBIENT_TEMP, vibration_sensor=0, door_locked=0.
  - All counters cleared; door FSM in UNLOCKED.
- Tick prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. Water, temperature and vibration update only on tick cycles. The door FSM runs on every clk.
- Water update on tick:
  - fill = (water_valve & ~inject_no_water) ? FILL_RATE : 0.
  - drn = (drain_pump & ~inject_drain_block) ? DRAIN_RATE : 0.
  - next = level + fill - drn, computed as 12-bit signed and clamped to [0, LEVEL_MAX].
  - Valve and pump both active: net effect is FILL_RATE - DRAIN_RATE (-4 with defaults). The result is visible on the cycle after the tick.
- Temperature:
  - heat_eff = heater & (level >= MIN_HEAT_LEVEL).
  - heat_eff=1: heat_cnt increments per tick; on reaching HEAT_DIV, temp+1 (capped at TEMP_MAX) and heat_cnt clears.
  - heat_eff=0: cool_cnt works the same way with COOL_DIV; temp-1, never below AMBIENT_TEMP.
  - Any change of heat_eff clears both counters.
  - Heater with an empty drum: temperature does not rise.
- Door FSM (per clk), with states UNLOCKED, LOCKING, LOCKED, UNLOCKING:
  - UNLOCKED: door_lock=1 -> LOCKING, delay counter cleared.
  - LOCKING: counts clk cycles. door_lock=0 -> UNLOCKED immediately. After LOCK_DELAY cycles -> LOCKED.
  - LOCKED: door_lock=0 -> UNLOCKING.
  - UNLOCKING: door_lock=1 -> LOCKED, counter cleared. -> UNLOCKED only once counter >= LOCK_DELAY AND level < DOOR_SAFE_LEVEL; otherwise the counter saturates and the FSM holds.
  - door_locked=1 in LOCKED and UNLOCKING; 0 in UNLOCKED and LOCKING (registered state decode).
- Vibration:
  - vib_cond = inject_imbalance & (drum_motor >= VIB_THRESH).
  - vib_cnt increments per tick while vib_cond=1 (saturates at VIB_PERSIST); vibration_sensor=1 when vib_cnt==VIB_PERSIST.
  - vib_cond=0 on any clk: vib_cnt and vibration_sensor clear on the next edge, without waiting for a tick.
- Simultaneous events: all update paths are independent, so one tick may change level, temperature and vibration together.

Test Plan:
- Fill: reset, then water_valve=1 for 25 ticks (125 clk) -> level=100. Continue for 300 ticks -> level clamps at 1023.
- Drain and overlap: from level 100, drain_pump=1 for 13 ticks -> level=0 and stays 0. Both valve and pump on from level 100 for 5 ticks -> 80. Repeat with inject_drain_block=1 -> level unchanged.
- Heating: level=0, heater=1 for 30 ticks -> temp stays 20. At level 100, heater=1 for 60 ticks -> temp=40. Then heater=0 for 100 ticks -> temp=30. Long cooling -> temp floors at 20.
- Door: door_lock=1 -> door_locked rises after 8+1 clk. Drop door_lock at 4 clk into locking -> door_locked stays 0. Unlock with level=100 -> door_locked held until drained below 10, then drops.
- Vibration: inject_imbalance=1 with drum_motor=13 -> vibration_sensor=1 after 4 ticks. drum_motor=11 -> never asserts. Drop inject_imbalance -> sensor=0 next cycle.
- Async reset mid-fill and mid-lock: assert reset between edges -> all outputs at reset values immediately, then the prescaler restarts from 0.

Source files
------------

// File: rtl/washing_machine_plant_model.sv
// rtl/washing_machine_plant_model.sv - cycle-based washer physics: water level, temperature, vibration, door lock
module washing_machine_plant_model #(
    parameter int TICK_DIV        = 5,
    parameter int FILL_RATE       = 4,
    parameter int DRAIN_RATE      = 8,
    parameter int LEVEL_MAX       = 1023,
    parameter int MIN_HEAT_LEVEL  = 50,
    parameter int HEAT_DIV        = 3,
    parameter int COOL_DIV        = 10,
    parameter int AMBIENT_TEMP    = 20,
    parameter int TEMP_MAX        = 100,
    parameter int LOCK_DELAY      = 8,
    parameter int DOOR_SAFE_LEVEL = 10,
    parameter int VIB_THRESH      = 12,
    parameter int VIB_PERSIST     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       water_valve,
    input  logic       drain_pump,
    input  logic       heater,
    input  logic [3:0] drum_motor,
    input  logic       door_lock,
    input  logic       inject_no_water,
    input  logic       inject_drain_block,
    input  logic       inject_imbalance,
    output logic [9:0] water_level_sensor,
    output logic [6:0] temperature_adc_sensor,
    output logic       vibration_sensor,
    output logic       door_locked
);

    localparam logic [7:0]         TICK_LAST  = 8'(TICK_DIV - 1);
    localparam logic signed [11:0] FILL_S     = 12'(FILL_RATE);
    localparam logic signed [11:0] DRAIN_S    = 12'(DRAIN_RATE);
    localparam logic signed [11:0] LVL_MAX_S  = 12'(LEVEL_MAX);
    localparam logic [9:0]         LVL_MAX    = 10'(LEVEL_MAX);
    localparam logic [9:0]         HEAT_LVL   = 10'(MIN_HEAT_LEVEL);
    localparam logic [9:0]         SAFE_LVL   = 10'(DOOR_SAFE_LEVEL);
    localparam logic [7:0]         HEAT_LAST  = 8'(HEAT_DIV - 1);
    localparam logic [7:0]         COOL_LAST  = 8'(COOL_DIV - 1);
    localparam logic [6:0]         T_AMB      = 7'(AMBIENT_TEMP);
    localparam logic [6:0]         T_MAX      = 7'(TEMP_MAX);
    localparam logic [7:0]         LOCK_LAST  = 8'(LOCK_DELAY - 1);
    localparam logic [7:0]         LOCK_DLY   = 8'(LOCK_DELAY);
    localparam logic [3:0]         VIB_TH     = 4'(VIB_THRESH);
    localparam logic [7:0]         VIB_P      = 8'(VIB_PERSIST);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED,
        UNLOCKING
    } door_state_t;

    logic [7:0]         tick_cnt;
    logic               tick;
    logic [9:0]         level;
    logic signed [11:0] level_sum;
    logic [9:0]         level_next;
    logic [6:0]         temp;
    logic [7:0]         heat_cnt;
    logic [7:0]         cool_cnt;
    logic               heat_eff;
    logic               heat_eff_q;
    logic [7:0]         vib_cnt;
    logic               vib_cond;
    door_state_t        state_q;
    door_state_t        state_d;
    logic [7:0]         lock_cnt_q;
    logic [7:0]         lock_cnt_d;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

    // Signed headroom lets the drain undershoot below zero before clamping.
    always_comb begin
        level_sum = $signed({2'b00, level})
                  + ((water_valve && !inject_no_water)   ? FILL_S  : 12'sd0)
                  - ((drain_pump  && !inject_drain_block) ? DRAIN_S : 12'sd0);
        if (level_sum < 12'sd0) begin
            level_next = '0;
        end else if (level_sum > LVL_MAX_S) begin
            level_next = LVL_MAX;
        end else begin
            level_next = level_sum[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else if (tick) begin
            level <= level_next;
        end
    end

    assign heat_eff = heater && (level >= HEAT_LVL);

    // A change in heating effect restarts both dividers so partial counts never carry over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp       <= T_AMB;
            heat_cnt   <= '0;
            cool_cnt   <= '0;
            heat_eff_q <= 1'b0;
        end else begin
            heat_eff_q <= heat_eff;
            if (heat_eff != heat_eff_q) begin
                heat_cnt <= '0;
                cool_cnt <= '0;
            end else if (tick) begin
                if (heat_eff) begin
                    if (heat_cnt == HEAT_LAST) begin
                        heat_cnt <= '0;
                        if (temp < T_MAX) begin
                            temp <= temp + 7'd1;
                        end
                    end else begin
                        heat_cnt <= heat_cnt + 8'd1;
                    end
                end else begin
                    if (cool_cnt == COOL_LAST) begin
                        cool_cnt <= '0;
                        if (temp > T_AMB) begin
                            temp <= temp - 7'd1;
                        end
                    end else begin
                        cool_cnt <= cool_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign vib_cond = inject_imbalance && (drum_motor >= VIB_TH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vib_cnt <= '0;
        end else if (!vib_cond) begin
            vib_cnt <= '0;
        end else if (tick && (vib_cnt != VIB_P)) begin
            vib_cnt <= vib_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            UNLOCKED: begin
                if (door_lock) begin
                    state_d    = LOCKING;
                    lock_cnt_d = '0;
                end
            end
            LOCKING: begin
                if (!door_lock) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            LOCKED: begin
                if (!door_lock) begin
                    state_d    = UNLOCKING;
                    lock_cnt_d = '0;
                end
            end
            UNLOCKING: begin
                // The latch stays engaged while the drum still holds water.
                if (door_lock) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else if ((lock_cnt_q >= LOCK_DLY) && (level < SAFE_LVL)) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q < LOCK_DLY) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase
    end

    assign water_level_sensor     = level;
    assign temperature_adc_sensor = temp;
    assign vibration_sensor       = (vib_cnt == VIB_P);
    assign door_locked            = (state_q == LOCKED) || (state_q == UNLOCKING);

endmodule

// File: tb/tb_washing_machine_plant_model.sv
// tb/tb_washing_machine_plant_model.sv - self-checking bench with a tick-level behavioural washer model
module tb_washing_machine_plant_model;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       water_valve = 1'b0;
    logic       drain_pump = 1'b0;
    logic       heater = 1'b0;
    logic [3:0] drum_motor = 4'd0;
    logic       door_lock = 1'b0;
    logic       inject_no_water = 1'b0;
    logic       inject_drain_block = 1'b0;
    logic       inject_imbalance = 1'b0;
    logic [9:0] water_level_sensor;
    logic [6:0] temperature_adc_sensor;
    logic       vibration_sensor;
    logic       door_locked;

    int n_cmp = 0;
    int n_fail = 0;

    int m_level;
    int m_temp;
    int m_run;
    bit m_prev_eff;
    int m_vib;

    washing_machine_plant_model dut (
        .clk                    (clk),
        .reset                  (reset),
        .water_valve            (water_valve),
        .drain_pump             (drain_pump),
        .heater                 (heater),
        .drum_motor             (drum_motor),
        .door_lock              (door_lock),
        .inject_no_water        (inject_no_water),
        .inject_drain_block     (inject_drain_block),
        .inject_imbalance       (inject_imbalance),
        .water_level_sensor     (water_level_sensor),
        .temperature_adc_sensor (temperature_adc_sensor),
        .vibration_sensor       (vibration_sensor),
        .door_locked            (door_locked)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        water_valve = 0; drain_pump = 0; heater = 0; drum_motor = 0; door_lock = 0;
        inject_no_water = 0; inject_drain_block = 0; inject_imbalance = 0;
    endtask

    task automatic model_init();
        m_level = 0; m_temp = 20; m_run = 0; m_prev_eff = 0; m_vib = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        model_init();
    endtask

    // Advances n physics ticks (inputs held) and updates the reference model once per tick.
    task automatic run_ticks(input int n);
        int nl;
        bit eff;
        for (int k = 0; k < n; k++) begin
            repeat (5) @(posedge clk);
            #1;
            nl = m_level + ((water_valve && !inject_no_water) ? 4 : 0)
                         - ((drain_pump && !inject_drain_block) ? 8 : 0);
            eff = heater && (m_level >= 50);
            if (eff != m_prev_eff) begin
                m_run = 0;
                m_prev_eff = eff;
            end
            m_run++;
            if (eff && m_run == 3) begin
                m_run = 0;
                if (m_temp < 100) m_temp++;
            end else if (!eff && m_run == 10) begin
                m_run = 0;
                if (m_temp > 20) m_temp--;
            end
            m_level = (nl < 0) ? 0 : (nl > 1023) ? 1023 : nl;
            if (inject_imbalance && drum_motor >= 12) m_vib = (m_vib < 4) ? m_vib + 1 : 4;
            else m_vib = 0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", water_level_sensor); end
        n_cmp++; if (temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL reset_temp got %0d want 20", temperature_adc_sensor); end
        n_cmp++; if (vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL reset_vib got %0b want 0", vibration_sensor); end
        n_cmp++; if (door_locked !== 1'b0) begin n_fail++; $display("FAIL reset_door got %0b want 0", door_locked); end
    endtask

    task automatic test_fill();
        apply_reset();
        water_valve = 1;
        run_ticks(25);
        n_cmp++; if (water_level_sensor !== 10'd100) begin n_fail++; $display("FAIL fill_100 got %0d want 100", water_level_sensor); end
        run_ticks(300);
        n_cmp++; if (water_level_sensor !== 10'd1023 || m_level != 1023) begin n_fail++; $display("FAIL fill_clamp got %0d want 1023", water_level_sensor); end
    endtask

    task automatic test_drain();
        apply_reset();
        water_valve = 1;
        run_ticks(25);
        water_valve = 0; drain_pump = 1;
        run_ticks(13);
        n_cmp++; if (water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL drain_empty got %0d want 0", water_level_sensor); end
        run_ticks(3);
        n_cmp++; if (water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL drain_stays0 got %0d want 0", water_level_sensor); end
        drain_pump = 0; water_valve = 1;
        run_ticks(25);
        drain_pump = 1;
        run_ticks(5);
        n_cmp++; if (water_level_sensor !== 10'd80) begin n_fail++; $display("FAIL overlap got %0d want 80", water_level_sensor); end
        water_valve = 0; inject_drain_block = 1;
        run_ticks(5);
        n_cmp++; if (water_level_sensor !== 10'd80) begin n_fail++; $display("FAIL drain_block got %0d want 80", water_level_sensor); end
        drain_pump = 0; inject_drain_block = 0; inject_no_water = 1; water_valve = 1;
        run_ticks(5);
        n_cmp++; if (water_level_sensor !== 10'd80) begin n_fail++; $display("FAIL no_water got %0d want 80", water_level_sensor); end
    endtask

    task automatic test_heating();
        apply_reset();
        heater = 1;
        run_ticks(30);
        n_cmp++; if (temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL heat_empty got %0d want 20", temperature_adc_sensor); end
        heater = 0; water_valve = 1;
        run_ticks(25);
        water_valve = 0; heater = 1;
        run_ticks(60);
        n_cmp++; if (temperature_adc_sensor !== 7'd40) begin n_fail++; $display("FAIL heat_40 got %0d want 40", temperature_adc_sensor); end
        heater = 0;
        run_ticks(100);
        n_cmp++; if (temperature_adc_sensor !== 7'd30) begin n_fail++; $display("FAIL cool_30 got %0d want 30", temperature_adc_sensor); end
        run_ticks(300);
        n_cmp++; if (temperature_adc_sensor !== 7'd20) begin n_fail++; $display("FAIL cool_floor got %0d want 20", temperature_adc_sensor); end
    endtask

    task automatic test_door();
        bit seen;
        apply_reset();
        door_lock = 1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (door_locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %0b want 0", door_locked); end
        @(posedge clk); #1;
        n_cmp++; if (door_locked !== 1'b1) begin n_fail++; $display("FAIL lock_9clk got %0b want 1", door_locked); end

        apply_reset();
        door_lock = 1;
        repeat (4) @(posedge clk);
        #1 door_lock = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (door_locked) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL lock_abort got %0b want 0", seen); end

        apply_reset();
        water_valve = 1;
        run_ticks(25);
        water_valve = 0; door_lock = 1;
        run_ticks(2);
        n_cmp++; if (door_locked !== 1'b1) begin n_fail++; $display("FAIL lock_full got %0b want 1", door_locked); end
        door_lock = 0;
        run_ticks(4);
        n_cmp++; if (door_locked !== 1'b1) begin n_fail++; $display("FAIL unlock_wet got %0b want 1", door_locked); end
        drain_pump = 1;
        for (int i = 0; i < 20 && m_level >= 10; i++) run_ticks(1);
        n_cmp++; if (water_level_sensor !== 10'(m_level) || m_level >= 10) begin n_fail++; $display("FAIL unlock_drain_level got %0d want %0d", water_level_sensor, m_level); end
        n_cmp++; if (door_locked !== 1'b1) begin n_fail++; $display("FAIL unlock_pre got %0b want 1", door_locked); end
        @(posedge clk); #1;
        n_cmp++; if (door_locked !== 1'b0) begin n_fail++; $display("FAIL unlock_dry got %0b want 0", door_locked); end
    endtask

    task automatic test_vibration();
        bit seen;
        apply_reset();
        inject_imbalance = 1; drum_motor = 13;
        run_ticks(3);
        n_cmp++; if (vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL vib_early got %0b want 0", vibration_sensor); end
        run_ticks(1);
        n_cmp++; if (vibration_sensor !== 1'b1) begin n_fail++; $display("FAIL vib_4ticks got %0b want 1", vibration_sensor); end
        drum_motor = 11;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            run_ticks(1);
            if (vibration_sensor) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL vib_low_speed got %0b want 0", seen); end
        drum_motor = 13;
        run_ticks(6);
        n_cmp++; if (vibration_sensor !== 1'b1) begin n_fail++; $display("FAIL vib_resume got %0b want 1", vibration_sensor); end
        inject_imbalance = 0;
        @(posedge clk); #1;
        n_cmp++; if (vibration_sensor !== 1'b0) begin n_fail++; $display("FAIL vib_drop got %0b want 0", vibration_sensor); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        water_valve = 1; heater = 1;
        run_ticks(3);
        door_lock = 1;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        #1;
        n_cmp++; if (water_level_sensor !== 10'd0 || temperature_adc_sensor !== 7'd20 || vibration_sensor !== 1'b0 || door_locked !== 1'b0)
            begin n_fail++; $display("FAIL async_reset got lvl=%0d t=%0d v=%0b d=%0b want 0/20/0/0",
                water_level_sensor, temperature_adc_sensor, vibration_sensor, door_locked); end
        @(negedge clk);
        door_lock = 0;
        reset = 1;
        model_init();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (water_level_sensor !== 10'd0) begin n_fail++; $display("FAIL prescale_restart_pre got %0d want 0", water_level_sensor); end
        @(posedge clk); #1;
        n_cmp++; if (water_level_sensor !== 10'd4) begin n_fail++; $display("FAIL prescale_restart got %0d want 4", water_level_sensor); end
    endtask

    task automatic test_random();
        int hold;
        apply_reset();
        for (int s = 0; s < 60; s++) begin
            water_valve        = ($urandom_range(0, 9) < 6);
            drain_pump         = ($urandom_range(0, 9) < 3);
            heater             = $urandom_range(0, 1);
            drum_motor         = 4'($urandom_range(0, 15));
            inject_no_water    = ($urandom_range(0, 9) == 0);
            inject_drain_block = ($urandom_range(0, 9) == 0);
            inject_imbalance   = ($urandom_range(0, 3) != 0);
            hold = $urandom_range(1, 8);
            for (int t = 0; t < hold; t++) begin
                run_ticks(1);
                n_cmp++; if (water_level_sensor !== 10'(m_level)) begin n_fail++; $display("FAIL rnd_level seg%0d got %0d want %0d", s, water_level_sensor, m_level); end
                n_cmp++; if (temperature_adc_sensor !== 7'(m_temp)) begin n_fail++; $display("FAIL rnd_temp seg%0d got %0d want %0d", s, temperature_adc_sensor, m_temp); end
                n_cmp++; if (vibration_sensor !== (m_vib == 4)) begin n_fail++; $display("FAIL rnd_vib seg%0d got %0b want %0b", s, vibration_sensor, (m_vib == 4)); end
            end
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_fill();
        test_drain();
        test_heating();
        test_door();
        test_vibration();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
